// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_e       - FSM encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/result width
//   ref_sub()     - reference difference {borrow, c - b} for widths up to 32
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Returns {borrow, difference}; both operands are truncated to width bits.
  function automatic logic [32:0] ref_sub(input logic [31:0] c_val,
                                          input logic [31:0] b_val,
                                          input int unsigned width);
    logic [31:0] mask;
    logic [31:0] cm;
    logic [31:0] bm;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    cm   = c_val & mask;
    bm   = b_val & mask;
    return {(cm < bm), ((cm - bm) & mask)};
  endfunction

endpackage

// File: rtl/serial_sub_fs_bit.sv
// fs_bit: single-bit combinational full subtractor.
//   ci     - minuend bit
//   bi     - subtrahend bit
//   br_in  - borrow in from the previous (less significant) bit
//   d      - difference bit
//   br_out - borrow out to the next bit
module fs_bit (
  input  logic ci,
  input  logic bi,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = ci ^ bi ^ br_in;
  // Borrow when ci < bi, or when the bits are equal and a borrow ripples in.
  assign br_out = (~ci & bi) | (~(ci ^ bi) & br_in);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, a = c - b (mod 2^WIDTH), one bit per
// clock, LSB first.
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   start     - request, sampled only in IDLE or DONE
//   c, b      - minuend and subtrahend, captured on an accepted start
//   a         - difference, updated only on entry to DONE
//   borrow    - final borrow (1 when c < b unsigned)
//   busy      - high while in RUN
//   done      - one-cycle pulse when a/borrow become valid
//   dbg_state - current FSM state, for observation only
//
// Handshake: start is accepted on any edge where state is IDLE or DONE and
// start=1; the operands are captured on that same edge. done pulses for
// exactly one cycle WIDTH edges later; start while busy is ignored.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a,
  output logic             borrow,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] c_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    count;

  logic             d_bit;
  logic             br_next;
  logic             accept;
  logic [WIDTH-1:0] res_next;

  fs_bit u_fs_bit (
    .ci     (c_sh[0]),
    .bi     (b_sh[0]),
    .br_in  (br),
    .d      (d_bit),
    .br_out (br_next)
  );

  assign accept    = start && ((state == IDLE) || (state == DONE));
  // The difference bit enters at the MSB so the LSB lands in bit 0 after
  // WIDTH shifts.
  assign res_next  = {d_bit, res[WIDTH-1:1]};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      c_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      br     <= 1'b0;
      count  <= '0;
      a      <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        c_sh  <= c;
        b_sh  <= b;
        res   <= '0;
        br    <= 1'b0;
        count <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            c_sh <= c_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_next;
            br   <= br_next;
            if (count == LAST) begin
              count  <= '0;
              a      <= res_next;
              borrow <= br_next;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
  import serial_sub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, start16;
  logic [7:0]  c8, b8, a8;
  logic [15:0] c16, b16, a16;
  logic        br8, busy8, done8;
  logic        br16, busy16, done16;
  state_e      st8, st16;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .c(c8), .b(b8),
    .a(a8), .borrow(br8), .busy(busy8), .done(done8), .dbg_state(st8)
  );

  serial_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .c(c16), .b(b16),
    .a(a16), .borrow(br16), .busy(busy16), .done(done16), .dbg_state(st16)
  );

  // ---------------- driver tasks ----------------
  // Launches one 8-bit op and waits for done. lat is the index of the sample
  // (taken after each edge, the first one right after the start edge) where
  // done was seen, or -1 on timeout; busy_cnt counts samples with busy=1.
  task automatic run8(input logic [7:0] cv, input logic [7:0] bv,
                      output logic [7:0] ra, output logic rb,
                      output int lat, output int busy_cnt);
    @(negedge clk);
    start8 = 1'b1; c8 = cv; b8 = bv;
    lat = -1; busy_cnt = 0; ra = '0; rb = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      c8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      if (busy8) busy_cnt++;
      if (done8) begin
        lat = i; ra = a8; rb = br8;
        break;
      end
    end
  endtask

  task automatic run16(input logic [15:0] cv, input logic [15:0] bv,
                       output logic [15:0] ra, output logic rb,
                       output int lat);
    @(negedge clk);
    start16 = 1'b1; c16 = cv; b16 = bv;
    lat = -1; ra = '0; rb = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start16 = 1'b0;
      c16 = 16'($urandom_range(0, 65535));
      b16 = 16'($urandom_range(0, 65535));
      if (done16) begin
        lat = i; ra = a16; rb = br16;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    c8 = '0; b8 = '0; c16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({a8, br8, busy8, done8} !== 11'b0 || st8 !== IDLE) begin
        errors++;
        $display("FAIL reset8: a=%0d borrow=%0b busy=%0b done=%0b state=%0d, required all 0/IDLE",
                 a8, br8, busy8, done8, st8);
      end
      checks++;
      if ({a16, br16, busy16, done16} !== 19'b0 || st16 !== IDLE) begin
        errors++;
        $display("FAIL reset16: a=%0d borrow=%0b busy=%0b done=%0b state=%0d, required all 0/IDLE",
                 a16, br16, busy16, done16, st16);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] ra; logic rb; int lat; int bc;
    run8(8'd32, 8'd18, ra, rb, lat, bc);
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL basic_latency: got %0d, required 9", lat);
    end
    checks++;
    if (bc !== 8) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d, required 8", bc);
    end
    checks++;
    if (ra !== 8'd14 || rb !== 1'b0) begin
      errors++; $display("FAIL basic_result: a=%0d borrow=%0b, required a=14 borrow=0", ra, rb);
    end
    // Result holds through IDLE after the done pulse.
    repeat (2) @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || a8 !== 8'd14 || st8 !== IDLE) begin
      errors++;
      $display("FAIL basic_hold: done=%0b a=%0d state=%0d, required done=0 a=14 IDLE",
               done8, a8, st8);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] cv[3] = '{8'd14, 8'd255, 8'd0};
    logic [7:0] bv[3] = '{8'd18, 8'd1,   8'd0};
    logic [7:0] ea[3] = '{8'd252, 8'd254, 8'd0};
    logic       eb[3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] ra; logic rb; int lat; int bc;
    for (int k = 0; k < 3; k++) begin
      run8(cv[k], bv[k], ra, rb, lat, bc);
      checks++;
      if (lat !== 9 || ra !== ea[k] || rb !== eb[k]) begin
        errors++;
        $display("FAIL vector%0d: lat=%0d a=%0d borrow=%0b, required lat=9 a=%0d borrow=%0b",
                 k, lat, ra, rb, ea[k], eb[k]);
      end
    end
  endtask

  task automatic test_ignored_start(input logic [7:0] prev_a);
    int lat = -1; int extra = 0;
    @(negedge clk);
    start8 = 1'b1; c8 = 8'd100; b8 = 8'd37;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (i == 3) begin
        checks++;
        if (a8 !== prev_a || busy8 !== 1'b1) begin
          errors++;
          $display("FAIL ignore_hold: a=%0d busy=%0b, required a=%0d busy=1", a8, busy8, prev_a);
        end
        start8 = 1'b1; c8 = 8'd9; b8 = 8'd9;
      end
      if (done8) begin lat = i; break; end
    end
    checks++;
    if (lat !== 9 || a8 !== 8'd63 || br8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: lat=%0d a=%0d borrow=%0b, required lat=9 a=63 borrow=0",
               lat, a8, br8);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    checks++;
    if (extra !== 0 || a8 !== 8'd63) begin
      errors++;
      $display("FAIL ignore_no_extra: extra_done=%0d a=%0d, required 0 and a=63", extra, a8);
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0; int t1 = -1; int t2 = -1; int busy_bad = 0;
    @(negedge clk);
    start8 = 1'b1; c8 = 8'd200; b8 = 8'd55;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy8 !== !done8) busy_bad++;
      if (done8) begin
        seen++;
        if (seen == 1) begin
          t1 = i;
          checks++;
          if (a8 !== 8'd145 || br8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: a=%0d borrow=%0b, required a=145 borrow=0", a8, br8);
          end
          c8 = 8'd10; b8 = 8'd20;
        end else begin
          t2 = i;
          checks++;
          if (a8 !== 8'd246 || br8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: a=%0d borrow=%0b, required a=246 borrow=1", a8, br8);
          end
          start8 = 1'b0;
          break;
        end
      end
    end
    checks++;
    if (t1 !== 9 || t2 - t1 !== 9) begin
      errors++;
      $display("FAIL b2b_spacing: first=%0d spacing=%0d, required 9 and 9", t1, t2 - t1);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++;
      $display("FAIL b2b_busy: %0d samples with busy==done, required 0", busy_bad);
    end
    @(negedge clk);
    checks++;
    if (st8 !== IDLE || done8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: state=%0d done=%0b, required IDLE and 0", st8, done8);
    end
  endtask

  task automatic test_reset_mid_run();
    int extra = 0;
    logic [7:0] ra; logic rb; int lat; int bc;
    @(negedge clk);
    start8 = 1'b1; c8 = 8'd50; b8 = 8'd5;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (st8 !== IDLE || {a8, br8, busy8, done8} !== 11'b0) begin
      errors++;
      $display("FAIL midrst_state: state=%0d a=%0d borrow=%0b busy=%0b done=%0b, required IDLE and 0",
               st8, a8, br8, busy8, done8);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL midrst_no_done: got %0d pulses, required 0", extra);
    end
    run8(8'd50, 8'd5, ra, rb, lat, bc);
    checks++;
    if (lat !== 9 || ra !== 8'd45 || rb !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rerun: lat=%0d a=%0d borrow=%0b, required lat=9 a=45 borrow=0",
               lat, ra, rb);
    end
  endtask

  task automatic test_random8(input int n);
    logic [7:0] cv, bv, ra; logic rb; int lat; int bc; logic [32:0] exp;
    for (int k = 0; k < n; k++) begin
      cv = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      if (k == 0) begin cv = 8'd0;   bv = 8'd255; end
      if (k == 1) begin cv = 8'd255; bv = 8'd255; end
      exp = ref_sub({24'd0, cv}, {24'd0, bv}, 8);
      run8(cv, bv, ra, rb, lat, bc);
      checks++;
      if (lat !== 9 || ra !== exp[7:0] || rb !== exp[32] || 8'(ra + bv) !== cv) begin
        errors++;
        $display("FAIL rand8 c=%0d b=%0d: lat=%0d a=%0d borrow=%0b, required lat=9 a=%0d borrow=%0b",
                 cv, bv, lat, ra, rb, exp[7:0], exp[32]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_random16(input int n);
    logic [15:0] cv, bv, ra; logic rb; int lat; logic [32:0] exp;
    for (int k = 0; k < n; k++) begin
      cv = 16'($urandom_range(0, 65535));
      bv = 16'($urandom_range(0, 65535));
      if (k == 0) begin cv = 16'd0;      bv = 16'hFFFF; end
      if (k == 1) begin cv = 16'h8000;   bv = 16'h7FFF; end
      exp = ref_sub({16'd0, cv}, {16'd0, bv}, 16);
      run16(cv, bv, ra, rb, lat);
      checks++;
      if (lat !== 17 || ra !== exp[15:0] || rb !== exp[32] || 16'(ra + bv) !== cv) begin
        errors++;
        $display("FAIL rand16 c=%0d b=%0d: lat=%0d a=%0d borrow=%0b, required lat=17 a=%0d borrow=%0b",
                 cv, bv, lat, ra, rb, exp[15:0], exp[32]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_vectors();          // leaves a8 = 0 from 0 - 0
    test_ignored_start(8'd0);
    test_back_to_back();
    test_reset_mid_run();
    test_random8(1000);
    test_random16(1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor: the inverse of the team's 8-bit sum task. Given total c and operand b, it recovers a = c - b.
- Processes one bit per clock, LSB first, with a start/done handshake.
- Used where the summed operands from the adder path must be recovered without a parallel subtractor.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- c  input  WIDTH  minuend (total); captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- a  output  WIDTH  difference c - b mod 2^WIDTH; valid while done or IDLE-after-done.
- borrow  output  1  final borrow out (1 when c < b unsigned).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result becomes valid.

Behaviour:
- Reset values, applied at any clk edge with rst=1: state=IDLE, a=0, borrow=0, busy=0, done=0, internal count=0, shift registers=0.
- rst has priority over all other inputs, including mid-RUN. The operation is abandoned and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE, start=1: capture c, b into shift registers, clear the running borrow and count, go to RUN, busy=1. start=0: stay.
- RUN, each edge:
  - Take bit ci, bi (LSB of the shift registers).
  - d = ci ^ bi ^ br.
  - br_next = (~ci & bi) | (~(ci ^ bi) & br).
  - Shift d into the result MSB (result shifts right) and shift c, b right.
  - count increments.
  - On the edge processing bit WIDTH-1: go to DONE, busy=0, done=1, and drive a with the full result and borrow with br_next.
- DONE lasts exactly one cycle with done=1.
  - Next edge with start=1: accept the new operands and go to RUN. This is a back-to-back operation; done drops.
  - Next edge with start=0: go to IDLE, done=0.
- Latency: start sampled at edge k, then done=1 and a/borrow valid in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start during RUN is ignored. Operands c, b may change freely outside the capture edge.
- a and borrow hold their last values through IDLE until the next DONE. During RUN they keep their previous values; the partial result lives only in an internal register.
- Width rules:
  - count width is clog2(WIDTH).
  - Arithmetic is modulo 2^WIDTH. Wrap-around is signalled only through borrow.
  - The result satisfies a + b == c (mod 2^WIDTH).
- No X propagation from uncaptured inputs into outputs.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH constant;
  - a function for the reference model difference, used by the bench.
- One natural sub-module, fs_bit: combinational full subtractor cell with inputs ci, bi, br_in and outputs d, br_out. It is instantiated once in the datapath.
- The FSM, counter, and shift registers live in serial_sub.

Test Plan:
- rst=1 for 2 cycles, then idle -> a=0, borrow=0, busy=0, done=0 held. Drive start=1 with c=32, b=18 -> done pulse 8 cycles after the start edge, a=14, borrow=0, busy high for exactly 8 cycles.
- c=14, b=18 -> a=252, borrow=1. Then c=255, b=1 -> a=254, borrow=0. Then c=0, b=0 -> a=0, borrow=0.
- Pulse start again 3 cycles into RUN with c=9, b=9 -> ignored. The in-flight result (c=100, b=37) completes with a=63, and no extra done pulse follows.
- start held high across DONE: c=200, b=55, then c=10, b=20 -> a=145 then a=246/borrow=1. Done pulses 9 cycles apart; busy low only in the DONE cycles.
- Assert rst at RUN cycle 4 of c=50, b=5 -> next cycle state=IDLE, all outputs 0, no done pulse. A following start with c=50, b=5 gives a=45.
- Random regression, 1000 ops, WIDTH=8 and WIDTH=16 -> a + b == c mod 2^WIDTH and borrow == (c < b) for every op.
